sys_rst_req: RTL and testbench

- Reset-request controller in the clk_sys domain; the return path into system clock/reset generation.
- Collects reset triggers (keyed software write, watchdog expiry, external button) and produces a stretched request `rst_req`.
- `rst_req` drives the clock manager's `rst_in`: it resets the PLL, which relocks and re-issues `rst_sys`.
- Gives other blocks a `rst_warn` window to quiesce (e.g. USB detach) before the request asserts.

---
 rtl/sys_rst_pkg.sv | 24 ++
 rtl/sys_rst_req_if.sv | 13 +
 rtl/sys_rst_wdt.sv | 46 ++++
 rtl/sys_rst_req.sv | 142 ++++++++++++++
 tb/tb_sys_rst_req.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_rst_pkg.sv
// Shared definitions for the reset-request controller: register map, trigger
// cause codes and the request state machine encoding.
package sys_rst_pkg;

  localparam logic [1:0] AddrCtrl    = 2'd0;
  localparam logic [1:0] AddrWdtCfg  = 2'd1;
  localparam logic [1:0] AddrWdtKick = 2'd2;
  localparam logic [1:0] AddrStatus  = 2'd3;

  typedef enum logic [1:0] {
    CauseNone = 2'd0,
    CauseSw   = 2'd1,
    CauseWdt  = 2'd2,
    CauseBtn  = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StWarn   = 2'd1,
    StAssert = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/sys_rst_req_if.sv
// Register bus between a host and the reset-request controller: one outstanding
// access, held on cyc until a single-cycle ack.
interface sys_rst_req_if;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        cyc;
  logic        we;
  logic        ack;

  modport master (output addr, output wdata, output cyc, output we, input rdata, input ack);
  modport slave  (input addr, input wdata, input cyc, input we, output rdata, output ack);
endinterface

// File: rtl/sys_rst_wdt.sv
// Watchdog down-counter: loads or reloads on request, counts while enabled in
// RUN, and flags expiry when the count reaches zero.
module sys_rst_wdt
  import sys_rst_pkg::*;
#(
  parameter int unsigned WDT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WDT_W-1:0] load_val,
  input  logic             kick,
  input  logic [WDT_W-1:0] reload,
  input  logic             en,
  input  logic             run,
  output logic [WDT_W-1:0] cnt,
  output logic             trig
);

  logic [WDT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (kick) begin
      cnt_d = reload;
    end else if (en && run && (cnt_q != '0)) begin
      cnt_d = cnt_q - WDT_W'(1);
    end
  end

  // A count already at zero also fires, so an enabled zero reload expires at
  // once; a concurrent load or kick always wins over expiry.
  assign trig = en && run && !load && !kick && (cnt_q <= WDT_W'(1));
  assign cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sys_rst_req.sv
// Reset-request controller: collects sw/watchdog/button triggers, warns other
// blocks, then holds a stretched request to the clock manager.
module sys_rst_req
  import sys_rst_pkg::*;
#(
  parameter int unsigned WDT_W       = 24,
  parameter int unsigned WARN_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [15:0] KEY         = 16'hB007
) (
  input  logic               clk,
  input  logic               rst,
  sys_rst_req_if.slave       bus,
  input  logic               btn_req,
  output logic               rst_warn,
  output logic               rst_req,
  output logic [1:0]         cause
);

  localparam int unsigned PhMax = (WARN_CYCLES > HOLD_CYCLES) ? WARN_CYCLES : HOLD_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic             warn_q, req_q;
  logic             ack_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             wdt_en_q;
  logic [WDT_W-1:0] wdt_reload_q;
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_trig;

  logic acc, wr, rd, run, cfg_wr, kick, sw_trig;

  assign acc = bus.cyc && !ack_q;
  assign wr  = acc && bus.we;
  assign rd  = acc && !bus.we;
  assign run = (state_q == StRun);

  // Writes outside RUN are acked but must leave all state untouched.
  assign cfg_wr  = wr && run && (bus.addr == AddrWdtCfg);
  assign kick    = wr && run && (bus.addr == AddrWdtKick);
  assign sw_trig = wr && run && (bus.addr == AddrCtrl) && (bus.wdata[31:16] == KEY) &&
                   bus.wdata[0];

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  sys_rst_wdt #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .load     (cfg_wr),
    .load_val (bus.wdata[WDT_W-1:0]),
    .kick     (kick),
    .reload   (wdt_reload_q),
    .en       (wdt_en_q),
    .run      (run),
    .cnt      (wdt_cnt),
    .trig     (wdt_trig)
  );

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (bus.addr)
        AddrCtrl:    rdata_d = '0;
        AddrWdtCfg:  rdata_d = {wdt_en_q, 31'(wdt_reload_q)};
        AddrWdtKick: rdata_d = 32'(wdt_cnt);
        AddrStatus:  rdata_d = {28'b0, state_q, cause_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cause_d = cause_q;
    unique case (state_q)
      StRun: begin
        if (sw_trig || wdt_trig || btn_req) begin
          state_d = StWarn;
          phase_d = PhW'(WARN_CYCLES - 1);
          if (sw_trig)       cause_d = CauseSw;
          else if (wdt_trig) cause_d = CauseWdt;
          else               cause_d = CauseBtn;
        end
      end
      StWarn: begin
        if (phase_q == '0) begin
          state_d = StAssert;
          phase_d = PhW'(HOLD_CYCLES - 1);
        end else begin
          phase_d = phase_q - PhW'(1);
        end
      end
      StAssert: begin
        if (phase_q == '0) state_d = StDone;
        else               phase_d = phase_q - PhW'(1);
      end
      // Only the system reset, via PLL lock loss, leaves DONE.
      StDone: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      cause_q      <= CauseNone;
      phase_q      <= '0;
      warn_q       <= 1'b0;
      req_q        <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      wdt_en_q     <= 1'b0;
      wdt_reload_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      phase_q <= phase_d;
      warn_q  <= (state_d != StRun);
      req_q   <= (state_d == StAssert);
      ack_q   <= acc;
      rdata_q <= rdata_d;
      if (cfg_wr) begin
        wdt_en_q     <= bus.wdata[31];
        wdt_reload_q <= bus.wdata[WDT_W-1:0];
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign rst_warn  = warn_q;
  assign rst_req   = req_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_sys_rst_req.sv
// Bench for sys_rst_req: directed and randomised bus/button stimulus checked
// against a timeline model of trigger, warning and request windows.
module tb_sys_rst_req;

  localparam int          WARN = 64;
  localparam int          HOLD = 16;
  localparam logic [15:0] KEY  = 16'hB007;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_req = 1'b0;
  logic       rst_warn, rst_req;
  logic [1:0] cause;

  sys_rst_req_if bif ();

  sys_rst_req dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .btn_req  (btn_req),
    .rst_warn (rst_warn),
    .rst_req  (rst_req),
    .cause    (cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: the edge at which a trigger was taken, its cause, and the watchdog
  // expressed as last load/kick edge plus reload distance.
  int          trig_e = -1;
  logic [1:0]  cause_m = 2'd0;
  logic        en_m = 1'b0;
  logic [23:0] rel_m = '0;
  int          last_l = 0;
  bit          op_now = 1'b0;
  logic [31:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int st_m(input int k);
    if (trig_e < 0) return 0;
    if (k < trig_e + WARN) return 1;
    if (k < trig_e + WARN + HOLD) return 2;
    return 3;
  endfunction

  function automatic int deadline_m();
    return last_l + ((rel_m == 0) ? 1 : int'(rel_m));
  endfunction

  function automatic logic [31:0] read_m(input logic [1:0] a, input int k);
    int c;
    int kk;
    case (a)
      2'd0: return 32'h0;
      2'd1: return {en_m, 7'b0, rel_m};
      2'd2: begin
        if (!en_m) return 32'(rel_m);
        kk = (trig_e >= 0) ? trig_e : k;
        c = int'(rel_m) - (kk - last_l);
        if (c < 0) c = 0;
        return 32'(c);
      end
      default: return {28'b0, 2'(st_m(k)), cause_m};
    endcase
  endfunction

  task automatic step();
    int e;
    bit sw, wd, bt;
    e = edge_n + 1;
    if (op_now && !bif.we) exp_rd = read_m(bif.addr, edge_n);
    if (rst) begin
      trig_e = -1; cause_m = 2'd0; en_m = 1'b0; rel_m = '0; last_l = e;
    end else if (trig_e < 0) begin
      sw = op_now && bif.we && (bif.addr == 2'd0) && (bif.wdata[31:16] == KEY) && bif.wdata[0];
      wd = en_m && (e == deadline_m()) &&
           !(op_now && bif.we && (bif.addr == 2'd1 || bif.addr == 2'd2));
      bt = btn_req;
      if (sw || wd || bt) begin
        trig_e  = e;
        cause_m = sw ? 2'd1 : (wd ? 2'd2 : 2'd3);
      end
      if (op_now && bif.we && bif.addr == 2'd1) begin
        en_m = bif.wdata[31]; rel_m = bif.wdata[23:0]; last_l = e;
      end
      if (op_now && bif.we && bif.addr == 2'd2) last_l = e;
    end
    op_now = 1'b0;
    @(posedge clk);
    #1;
    edge_n = e;
    chk("rst_warn", 32'(rst_warn), 32'(trig_e >= 0));
    chk("rst_req", 32'(rst_req),
        32'(trig_e >= 0 && edge_n >= trig_e + WARN && edge_n < trig_e + WARN + HOLD));
    chk("cause", 32'(cause), 32'(cause_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_op(input bit we, input logic [1:0] a, input logic [31:0] d,
                        input string tag);
    bif.cyc = 1'b1; bif.we = we; bif.addr = a; bif.wdata = d; op_now = 1'b1;
    step();
    chk({tag, "_ack"}, 32'(bif.ack), 32'd1);
    if (!we) chk({tag, "_rdata"}, bif.rdata, exp_rd);
    bif.cyc = 1'b0; bif.we = 1'b0;
    step();
    chk({tag, "_ack_gap"}, 32'(bif.ack), 32'd0);
    chk({tag, "_rd_idle"}, bif.rdata, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int r, l0;
    bif.cyc = 1'b0; bif.we = 1'b0; bif.addr = 2'd0; bif.wdata = '0;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus_op(1'b0, 2'd3, 32'h0, "status_rst");
    bus_op(1'b0, 2'd1, 32'h0, "cfg_rst");
    bus_op(1'b0, 2'd2, 32'h0, "cnt_rst");

    // Wrong key and non-trigger CTRL writes
    bus_op(1'b1, 2'd0, 32'h1234_0001, "bad_key");
    idle(3);
    bus_op(1'b0, 2'd3, 32'h0, "status_badkey");
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      if (i % 2 == 1) begin
        d[31:16] = KEY; d[0] = 1'b0;
      end else if (d[31:16] == KEY) begin
        d[16] = ~d[16];
      end
      bus_op(1'b1, 2'd0, d, "bad_ctrl");
    end
    bus_op(1'b0, 2'd0, 32'h0, "ctrl_rd");
    bus_op(1'b0, 2'd3, 32'h0, "status_badctrl");

    // Disabled watchdog configuration readback
    for (int i = 0; i < 6; i++) begin
      bus_op(1'b1, 2'd1, $urandom & 32'h7fff_ffff, "cfg_wr");
      idle($urandom_range(0, 3));
      bus_op(1'b0, 2'd1, 32'h0, "cfg_rd");
      bus_op(1'b0, 2'd2, 32'h0, "cnt_rd");
      bus_op(1'b1, 2'd2, $urandom, "kick_dis");
      bus_op(1'b0, 2'd2, 32'h0, "cnt_rd_kick");
    end

    // Kicked watchdog, then expiry
    bus_op(1'b1, 2'd1, 32'h8000_0010, "wdt_cfg");
    for (int i = 0; i < 100; i++) begin
      idle($urandom_range(4, 12));
      bus_op(1'b1, 2'd2, $urandom, "kick");
    end
    idle(16 + WARN + HOLD + 5);
    bus_op(1'b0, 2'd3, 32'h0, "status_wdt_done");
    do_reset();

    // Keyed write with simultaneous button, later button noise and writes
    btn_req = 1'b1;
    bus_op(1'b1, 2'd0, {KEY, 16'h0001}, "sw_key");
    for (int i = 0; i < 20; i++) begin
      btn_req = 1'($urandom);
      step();
    end
    btn_req = 1'b0;
    bus_op(1'b1, 2'd1, $urandom, "cfg_ignored");
    bus_op(1'b1, 2'd2, $urandom, "kick_ignored");
    bus_op(1'b0, 2'd1, 32'h0, "cfg_unchanged");
    bus_op(1'b0, 2'd3, 32'h0, "status_sw_warn");
    idle(WARN + HOLD);
    bus_op(1'b0, 2'd3, 32'h0, "status_sw_done");
    do_reset();

    // Kick committed on the expiry cycle
    r = $urandom_range(8, 20);
    bus_op(1'b1, 2'd1, {1'b1, 7'b0, 24'(r)}, "coll_cfg");
    l0 = edge_n - 1;
    idle(l0 + r - 1 - edge_n);
    bus_op(1'b1, 2'd2, 32'h0, "coll_kick");
    bus_op(1'b0, 2'd2, 32'h0, "coll_cnt");
    bus_op(1'b1, 2'd1, 32'h0, "coll_off");
    idle(30);
    bus_op(1'b0, 2'd3, 32'h0, "status_coll");

    // Watchdog against button on the same edge
    r = $urandom_range(6, 20);
    bus_op(1'b1, 2'd1, {1'b1, 7'b0, 24'(r)}, "race_cfg");
    l0 = edge_n - 1;
    idle(l0 + r - 1 - edge_n);
    btn_req = 1'b1;
    step();
    btn_req = 1'b0;
    idle(WARN + HOLD + 2);
    bus_op(1'b0, 2'd3, 32'h0, "status_race");
    do_reset();

    // Keyed write against watchdog expiry on the same edge
    r = $urandom_range(6, 20);
    bus_op(1'b1, 2'd1, {1'b1, 7'b0, 24'(r)}, "race2_cfg");
    l0 = edge_n - 1;
    idle(l0 + r - 1 - edge_n);
    bus_op(1'b1, 2'd0, {KEY, 16'hFFFF}, "race2_sw");
    idle(WARN + HOLD + 2);
    bus_op(1'b0, 2'd3, 32'h0, "status_race2");
    do_reset();

    // Zero reload expires at once; reset lands in the 5th request cycle
    bus_op(1'b1, 2'd1, 32'h8000_0000, "wdt_zero");
    l0 = edge_n - 1;
    idle(l0 + 1 + WARN + 4 - edge_n);
    do_reset();
    bus_op(1'b0, 2'd3, 32'h0, "status_mid_rst");
    bus_op(1'b0, 2'd1, 32'h0, "cfg_mid_rst");

    // Button trigger
    idle($urandom_range(0, 5));
    btn_req = 1'b1;
    step();
    btn_req = 1'b0;
    idle(WARN + HOLD + 3);
    bus_op(1'b0, 2'd3, 32'h0, "status_btn");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
